// File: rtl/gb_wr_ctrl.sv
// Write-side controller for the global-buffer bank ring: streams words into banks
// round-robin, tracks per-bank full flags and releases them on reader completion.
module gb_wr_ctrl #(
    parameter int SRAM_ADDRWIDTH = 9,
    parameter int DATA_WIDTH     = 96,
    parameter int NUM_BANK       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                SRAM_num,
    input  logic [SRAM_ADDRWIDTH-1:0] fill_len,
    input  logic                      din_val,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      din_last,
    output logic                      din_rdy,
    output logic                      write_en,
    output logic [SRAM_ADDRWIDTH-1:0] addr_Wr,
    output logic [DATA_WIDTH-1:0]     data_Wr,
    output logic [3:0]                Wr_ID,
    input  logic [3:0]                Rd_ID,
    input  logic                      read_SRAM_done,
    output logic                      SRAM_prepare,
    output logic [NUM_BANK-1:0]       full_flags,
    output logic [1:0]                State_Wr,
    output logic                      write_done
);

    localparam logic [1:0] WR_IDLE  = 2'b00;
    localparam logic [1:0] WR_WAIT  = 2'b01;
    localparam logic [1:0] WR_WRITE = 2'b11;
    localparam logic [1:0] WR_DONE  = 2'b10;

    logic [1:0]                state_q, state_d;
    logic [3:0]                wr_id_q, wr_id_d;
    logic [3:0]                sram_num_q, sram_num_d;
    logic [SRAM_ADDRWIDTH-1:0] addr_q, addr_d;
    logic [SRAM_ADDRWIDTH-1:0] fill_len_q, fill_len_d;
    logic [NUM_BANK-1:0]       flags_q, flags_d;
    logic                      write_done_q, write_done_d;
    logic                      cur_full_s;
    logic                      hs_s;
    logic                      close_s;

    assign cur_full_s = flags_q[wr_id_q];

    // Output decode: ready, handshake and bank-close; start/rst cycles never write.
    always_comb begin
        if (state_q == WR_WRITE) begin
            din_rdy = ~cur_full_s;
        end else begin
            din_rdy = 1'b0;
        end
        hs_s    = din_val & din_rdy & ~start & ~rst;
        close_s = hs_s & ((addr_q == fill_len_q) | din_last);
    end

    assign write_en     = hs_s;
    assign data_Wr      = din;
    assign addr_Wr      = addr_q;
    assign Wr_ID        = wr_id_q;
    assign full_flags   = flags_q;
    assign State_Wr     = state_q;
    assign write_done   = write_done_q;
    assign SRAM_prepare = flags_q[Rd_ID];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start overrides every state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = WR_WAIT;
        end else begin
            case (state_q)
                WR_IDLE:  state_d = WR_IDLE;
                WR_WAIT:  state_d = cur_full_s ? WR_WAIT : WR_WRITE;
                WR_WRITE: begin
                    if (close_s) begin
                        state_d = din_last ? WR_DONE : WR_WAIT;
                    end else begin
                        state_d = WR_WRITE;
                    end
                end
                WR_DONE:  state_d = WR_IDLE;
                default:  state_d = WR_IDLE;
            endcase
        end
    end

    // Datapath next values: config capture, address/bank walk and flag set/clear.
    always_comb begin
        sram_num_d   = sram_num_q;
        fill_len_d   = fill_len_q;
        wr_id_d      = wr_id_q;
        addr_d       = addr_q;
        flags_d      = flags_q;
        write_done_d = 1'b0;
        if (start) begin
            sram_num_d = SRAM_num;
            fill_len_d = fill_len;
            wr_id_d    = 4'd0;
            addr_d     = '0;
            flags_d    = '0;
        end else begin
            if (read_SRAM_done) begin
                flags_d[Rd_ID] = 1'b0;
            end else begin
                flags_d = flags_q;
            end
            // Set is applied after clear so a same-bank collision keeps the bank full.
            if (close_s) begin
                flags_d[wr_id_q] = 1'b1;
                addr_d           = '0;
                wr_id_d          = (wr_id_q == sram_num_q) ? 4'd0 : wr_id_q + 4'd1;
                write_done_d     = din_last;
            end else if (hs_s) begin
                addr_d = addr_q + SRAM_ADDRWIDTH'(1);
            end else begin
                addr_d = addr_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_num_q   <= 4'd0;
            fill_len_q   <= '0;
            wr_id_q      <= 4'd0;
            addr_q       <= '0;
            flags_q      <= '0;
            write_done_q <= 1'b0;
        end else begin
            sram_num_q   <= sram_num_d;
            fill_len_q   <= fill_len_d;
            wr_id_q      <= wr_id_d;
            addr_q       <= addr_d;
            flags_q      <= flags_d;
            write_done_q <= write_done_d;
        end
    end

endmodule

// File: doc/gb_wr_ctrl.md
Name: gb_wr_ctrl

Overview:
- Write-side controller for the global-buffer SRAM bank ring; sits directly upstream of the per-bank read controller.
- Accepts a valid/ready word stream and fills banks 0..SRAM_num in round-robin order, one bank at a time.
- Marks each filled bank full and exposes SRAM_prepare for the bank the reader currently targets (Rd_ID).
- Frees a bank when the reader reports read_SRAM_done, giving back-pressure when all banks are full.

Parameters:
SRAM_ADDRWIDTH, 9, address width of one bank (depth 2^SRAM_ADDRWIDTH words)
DATA_WIDTH, 96, width of one stream word / SRAM word
NUM_BANK, 16, number of physical banks; flag vector width; Wr_ID is 4 bits

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; captures config, clears state, begins a layer
SRAM_num  in  4  index of the last bank in the ring (ring size = SRAM_num+1); sampled on start
fill_len  in  SRAM_ADDRWIDTH  last address written per bank (fill_len+1 words); sampled on start
din_val  in  1  stream word valid
din  in  DATA_WIDTH  stream word
din_last  in  1  qualifies the final word of the layer
din_rdy  out  1  stream ready
write_en  out  1  SRAM write strobe, combinational
addr_Wr  out  SRAM_ADDRWIDTH  write address
data_Wr  out  DATA_WIDTH  write data (= din)
Wr_ID  out  4  bank currently written
Rd_ID  in  4  bank the reader targets
read_SRAM_done  in  1  one-cycle pulse: reader finished bank Rd_ID
SRAM_prepare  out  1  full_flags[Rd_ID]
full_flags  out  NUM_BANK  per-bank full status
State_Wr  out  2  FSM state
write_done  out  1  one-cycle pulse after the last word is committed

Behaviour:
- Reset (rst=1 at a clk edge) puts the block in this state:
  - State_Wr=WR_IDLE; Wr_ID=0; addr_Wr=0; full_flags=0; write_done=0.
  - Captured SRAM_num and fill_len are cleared to 0.
  - Outputs: din_rdy=0, write_en=0, SRAM_prepare=0.
- FSM encoding: WR_IDLE=2'b00, WR_WAIT=2'b01, WR_WRITE=2'b11, WR_DONE=2'b10.
- start takes effect from any state and has priority over everything except rst:
  - Captures SRAM_num and fill_len.
  - Sets Wr_ID=0, addr_Wr=0, full_flags=0.
  - Next state is WR_WAIT.
  - A start during WR_WRITE aborts; any handshake in that cycle is discarded.
- WR_IDLE: din_rdy=0; stays in WR_IDLE until start.
- WR_WAIT: din_rdy=0; moves to WR_WRITE the cycle after full_flags[Wr_ID]==0.
- WR_WRITE:
  - din_rdy = ~full_flags[Wr_ID].
  - A handshake is din_val & din_rdy. In that same cycle: write_en=1, addr_Wr is the current address, data_Wr=din.
  - Bank-close condition: a handshake with addr_Wr==fill_len or din_last=1. On that edge:
    - full_flags[Wr_ID] is set; addr_Wr returns to 0.
    - Wr_ID advances, wrapping SRAM_num -> 0.
    - Next state is WR_DONE if din_last, else WR_WAIT.
  - Any other handshake: addr_Wr increments by 1.
- WR_DONE: write_done=1 for exactly one cycle, then WR_IDLE.
  - full_flags is kept, so the reader can drain the remaining banks.
- Release: read_SRAM_done clears full_flags[Rd_ID] at the next edge, in any state except a start/rst cycle.
  - If a set and a clear target the same bank in the same cycle, the set wins.
- SRAM_prepare = full_flags[Rd_ID], combinational.
- Wr_ID and Rd_ID values above SRAM_num are never generated by this block. An externally supplied Rd_ID out of ring range indexes the flags without being checked.
- Latency:
  - A word is committed in its handshake cycle.
  - The full flag is visible one cycle after the closing handshake.
  - A freed bank allows writing two cycles after read_SRAM_done: flag clears, then WR_WAIT to WR_WRITE.

Test Plan:
1. start with SRAM_num=1, fill_len=3; stream 8 words, last on word 8, no reads -> bank0 gets addr 0..3, bank1 gets addr 0..3; full_flags=2'b11; write_done pulses once; State_Wr ends at 2'b00.
2. SRAM_num=1, fill_len=3; stream 12 words with Rd_ID=0 and no done -> after 8 words din_rdy=0 in WR_WAIT with Wr_ID=0. Pulse read_SRAM_done -> full_flags[0]=0 next cycle; the 9th word is written to bank0 addr 0 two cycles after the pulse.
3. din_last on word 2 with fill_len=7 -> bank0 holds addr 0..1; full_flags[0]=1; Wr_ID=1; write_done pulses; SRAM_prepare=1 when Rd_ID=0.
4. start asserted mid-bank (addr_Wr=5, full_flags=0x3) -> next cycle State_Wr=2'b01, addr_Wr=0, Wr_ID=0, full_flags=0; the concurrent handshake produces no write.
5. Wr_ID=Rd_ID=2 with flag clear; closing handshake and read_SRAM_done arrive in the same cycle -> full_flags[2]=1 (set wins).
6. rst held high for one cycle mid-WR_WRITE -> all outputs at their reset values the next cycle; din_val ignored until a new start.
